// File: rtl/register_file_pkg.sv
// Shared widths and types for the architectural register file.
package register_file_pkg;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;
endpackage

// File: rtl/register_file.sv
// Architectural register file with per-register ROB rename tags, commit-side
// read bypass, and mispredict flush of all outstanding renames.
module register_file
    import register_file_pkg::*;
#(
    parameter int               REG_NUM  = 32,
    parameter int               TAG_W    = 5,
    parameter logic [TAG_W-1:0] NULL_TAG = 5'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             commit_enable,
    input  idx_t             commit_rd,
    input  data_t            commit_value,
    input  logic [TAG_W-1:0] commit_rename,
    input  logic             issue_enable,
    input  idx_t             issue_rd,
    input  logic [TAG_W-1:0] issue_rename,
    input  idx_t             rs1_index,
    input  idx_t             rs2_index,
    output data_t            rs1_value,
    output data_t            rs2_value,
    output logic [TAG_W-1:0] rs1_rename,
    output logic [TAG_W-1:0] rs2_rename
);

    data_t            value_q [REG_NUM];
    logic [TAG_W-1:0] tag_q   [REG_NUM];

    logic commit_hit;
    logic issue_hit;

    assign commit_hit = commit_enable && (commit_rd != '0);
    assign issue_hit  = issue_enable && (issue_rd != '0) && !flush;

    // Entry 0 is never written, so it holds its reset contents (0 / NULL_TAG).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= NULL_TAG;
            end
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_hit && (commit_rd == idx_t'(i))) begin
                    value_q[i] <= commit_value;
                end
                // Flush beats issue; issue beats the commit-side tag clear, so
                // a younger rename is never lost.
                if (flush) begin
                    tag_q[i] <= NULL_TAG;
                end else if (issue_hit && (issue_rd == idx_t'(i))) begin
                    tag_q[i] <= issue_rename;
                end else if (commit_hit && (commit_rd == idx_t'(i)) &&
                             (tag_q[i] == commit_rename)) begin
                    tag_q[i] <= NULL_TAG;
                end
            end
        end
    end

    // Returns {value, tag} for one read port; a matching commit is forwarded
    // so the reader does not wait a cycle for the result it depends on.
    function automatic logic [DATA_W+TAG_W-1:0] read_port(input idx_t idx);
        logic [DATA_W+TAG_W-1:0] res;
        res = {data_t'(0), NULL_TAG};
        if (idx != '0) begin
            if (commit_enable && (commit_rd == idx) && (tag_q[idx] == commit_rename)) begin
                res = {commit_value, NULL_TAG};
            end else begin
                res = {value_q[idx], tag_q[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {rs1_value, rs1_rename} = read_port(rs1_index);
        {rs2_value, rs2_rename} = read_port(rs2_index);
    end

endmodule
